// File: rtl/param_counter_if.sv
// param_counter_if -- control and status bundle for param_counter.
//
// Signals (WIDTH = count width):
//   en, up, sat_mode  step enable, direction (1 = up), boundary mode (1 = saturate)
//   clr, load         synchronous clear / parallel load (clr has priority)
//   load_val          value for load, clamped to MAX by the counter
//   flag_clr          clears the sticky ovf flag
//   count             registered count value
//   at_max, at_zero   combinational decodes of count
//   wrap              one-cycle pulse following a wrap step
//   ovf               sticky boundary-event flag
//
// Handshake: there is no valid/ready pair. Every control is a level that is
// sampled on each rising clk edge, and every status is valid in every cycle.
// The master (stimulus side) drives controls; the slave (counter) drives status.
interface param_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             sat_mode;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             flag_clr;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, sat_mode, clr, load, load_val, flag_clr,
    input  count, at_max, at_zero, wrap, ovf
  );

  modport slave (
    input  en, up, sat_mode, clr, load, load_val, flag_clr,
    output count, at_max, at_zero, wrap, ovf
  );
endinterface

// File: rtl/param_counter.sv
// param_counter -- up/down modulo counter with wrap or saturate boundary mode.
//
// Parameters:
//   WIDTH    count register width (2..32)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high; forces count=0, wrap=0, ovf=0
//   bus      param_counter_if slave modport (controls in, status out)
//
// Per-cycle priority: clr > load > en step > hold. A step past a boundary
// either wraps (pulsing wrap the next cycle) or holds, depending on sat_mode;
// both cases set ovf. Loads never count as boundary events.
module param_counter #(
  parameter int             WIDTH   = 8,
  parameter longint unsigned MODULUS = 256
) (
  input logic            clk,
  input logic            reset,
  param_counter_if.slave bus
);

  // MODULUS may be 2**WIDTH, so MAX is formed in 64 bits and then narrowed;
  // all counter arithmetic below stays in WIDTH bits and never needs MODULUS.
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_set = 1'b0;

    if (bus.clr) begin
      count_d = ZERO;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count_q == MAX) begin
          ovf_set = 1'b1;
          if (!bus.sat_mode) begin
            count_d = ZERO;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == ZERO) begin
          ovf_set = 1'b1;
          if (!bus.sat_mode) begin
            count_d = MAX;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end

    // A boundary event in the same cycle as flag_clr keeps the flag set.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (bus.flag_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= ZERO;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.ovf     = ovf_q;
  assign bus.at_max  = (count_q == MAX);
  assign bus.at_zero = (count_q == ZERO);

endmodule
